// File: rtl/bus_addr_sequencer_if.sv
// Address-burst bus between the sequencer (master) and its command source / decoder (slave).
interface bus_addr_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              busy;
  logic              done;
  logic [LEN_W:0]    beat_cnt;
  logic              timeout_err;

  modport master (
    input  start, start_addr, burst_len, addr_ready,
    output addr, addr_valid, busy, done, beat_cnt, timeout_err
  );

  modport slave (
    output start, start_addr, burst_len, addr_ready,
    input  addr, addr_valid, busy, done, beat_cnt, timeout_err
  );
endinterface

// File: rtl/bus_addr_sequencer.sv
// Burst address sequencer: issues burst_len+1 consecutive addresses over valid/ready.
// Optional stall abort is compiled in with `define SEQ_STALL_TIMEOUT_EN.
module bus_addr_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  bus_addr_sequencer_if.master        bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
  logic              xfer;

  assign xfer = (state_q == S_ISSUE) && bus.addr_ready;

`ifdef SEQ_STALL_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
`ifdef SEQ_STALL_TIMEOUT_EN
    stall_d       = stall_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d     = bus.start_addr;
          len_d      = bus.burst_len;
          beat_cnt_d = '0;
          state_d    = S_ISSUE;
`ifdef SEQ_STALL_TIMEOUT_EN
          stall_d       = '0;
          timeout_err_d = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        if (xfer) begin
          addr_d     = addr_q + 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          // beat_cnt_q counts beats already done, so equality marks the final beat
          if (beat_cnt_q == {1'b0, len_q}) state_d = S_DONE;
`ifdef SEQ_STALL_TIMEOUT_EN
          stall_d = '0;
        end else if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
          stall_d       = '0;
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          stall_d = stall_q + 1'b1;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
`ifdef SEQ_STALL_TIMEOUT_EN
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef SEQ_STALL_TIMEOUT_EN
      stall_q       <= stall_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr_valid = (state_q == S_ISSUE);
  assign bus.busy       = (state_q == S_ISSUE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.beat_cnt   = beat_cnt_q;
`ifdef SEQ_STALL_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_bus_addr_sequencer.sv
// Directed bench for bus_addr_sequencer; outputs sampled on the falling edge.
module tb_bus_addr_sequencer;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  bus_addr_sequencer_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  bus_addr_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse start for one edge; returns at the negedge where the first address is visible.
  task automatic kick(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = a; bus.burst_len = l;
    @(negedge clk);
    bus.start = 1'b0; bus.start_addr = 4'hf; bus.burst_len = 4'h0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.start_addr = '0; bus.burst_len = '0; bus.addr_ready = 1'b1;
    #12;
    vecs++;
    if ({bus.addr, bus.addr_valid, bus.busy, bus.done, bus.beat_cnt, bus.timeout_err} !== 13'b0) begin
      errs++; $display("FAIL reset_state got addr=%h v=%b b=%b d=%b cnt=%0d te=%b exp all 0",
                       bus.addr, bus.addr_valid, bus.busy, bus.done, bus.beat_cnt, bus.timeout_err);
    end
    rst_n = 1'b1;
    kick(4'b0101, 4'd7);
    @(negedge clk); @(negedge clk);
    vecs++;
    if (bus.addr !== 4'b0111 || bus.beat_cnt !== 5'd2) begin
      errs++; $display("FAIL reset_pre got addr=%b cnt=%0d exp 0111/2", bus.addr, bus.beat_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({bus.addr, bus.addr_valid, bus.busy, bus.beat_cnt} !== 11'b0) begin
      errs++; $display("FAIL reset_mid got addr=%h v=%b b=%b cnt=%0d exp 0/0/0/0",
                       bus.addr, bus.addr_valid, bus.busy, bus.beat_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if (bus.addr_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errs++; $display("FAIL reset_idle got v=%b b=%b exp 0/0", bus.addr_valid, bus.busy);
      end
    end
  endtask

  task automatic test_basic();
    bus.addr_ready = 1'b1;
    kick(4'b0000, 4'd3);
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (bus.addr !== 4'(i) || bus.addr_valid !== 1'b1 || bus.busy !== 1'b1) begin
        errs++; $display("FAIL basic_beat%0d got addr=%b v=%b exp %b/1", i, bus.addr, bus.addr_valid, 4'(i));
      end
      @(negedge clk);
    end
    vecs++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.addr_valid !== 1'b0 ||
        bus.beat_cnt !== 5'd4 || bus.addr !== 4'b0100) begin
      errs++; $display("FAIL basic_done got d=%b b=%b v=%b cnt=%0d addr=%b exp 1/0/0/4/0100",
                       bus.done, bus.busy, bus.addr_valid, bus.beat_cnt, bus.addr);
    end
    @(negedge clk);
    vecs++;
    if (bus.done !== 1'b0 || bus.beat_cnt !== 5'd4 || bus.timeout_err !== 1'b0) begin
      errs++; $display("FAIL basic_after got d=%b cnt=%0d te=%b exp 0/4/0", bus.done, bus.beat_cnt, bus.timeout_err);
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a [3];
    exp_a[0] = 4'b1110; exp_a[1] = 4'b1111; exp_a[2] = 4'b0000;
    bus.addr_ready = 1'b1;
    kick(4'b1110, 4'd2);
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (bus.addr !== exp_a[i] || bus.addr_valid !== 1'b1) begin
        errs++; $display("FAIL wrap_beat%0d got addr=%b v=%b exp %b/1", i, bus.addr, bus.addr_valid, exp_a[i]);
      end
      @(negedge clk);
    end
    vecs++;
    if (bus.done !== 1'b1 || bus.beat_cnt !== 5'd3 || bus.addr !== 4'b0001) begin
      errs++; $display("FAIL wrap_done got d=%b cnt=%0d addr=%b exp 1/3/0001", bus.done, bus.beat_cnt, bus.addr);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus.addr_ready = 1'b1;
    kick(4'b0000, 4'd3);
    @(negedge clk);
    bus.addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if (bus.addr !== 4'b0001 || bus.addr_valid !== 1'b1 || bus.beat_cnt !== 5'd1) begin
        errs++; $display("FAIL bp_hold%0d got addr=%b v=%b cnt=%0d exp 0001/1/1",
                         i, bus.addr, bus.addr_valid, bus.beat_cnt);
      end
    end
    bus.addr_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      vecs++;
      if (bus.addr !== 4'(i) || bus.addr_valid !== 1'b1) begin
        errs++; $display("FAIL bp_beat%0d got addr=%b exp %b", i, bus.addr, 4'(i));
      end
      @(negedge clk);
    end
    vecs++;
    if (bus.done !== 1'b1 || bus.beat_cnt !== 5'd4) begin
      errs++; $display("FAIL bp_done got d=%b cnt=%0d exp 1/4", bus.done, bus.beat_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    bus.addr_ready = 1'b1;
    kick(4'b0000, 4'd3);
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (bus.addr !== 4'(i)) begin
        errs++; $display("FAIL ign_beat%0d got addr=%b exp %b", i, bus.addr, 4'(i));
      end
      bus.start = (i > 0); bus.start_addr = 4'b1000; bus.burst_len = 4'd1;
      @(negedge clk);
    end
    // start still high in DONE must also be dropped
    vecs++;
    if (bus.done !== 1'b1) begin
      errs++; $display("FAIL ign_done got d=%b exp 1", bus.done);
    end
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (bus.addr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.beat_cnt !== 5'd4) begin
        errs++; $display("FAIL ign_idle%0d got v=%b b=%b cnt=%0d exp 0/0/4",
                         i, bus.addr_valid, bus.busy, bus.beat_cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_len_edges();
    bus.addr_ready = 1'b1;
    kick(4'b1001, 4'd0);
    vecs++;
    if (bus.addr !== 4'b1001 || bus.addr_valid !== 1'b1) begin
      errs++; $display("FAIL len0_beat got addr=%b v=%b exp 1001/1", bus.addr, bus.addr_valid);
    end
    @(negedge clk);
    vecs++;
    if (bus.done !== 1'b1 || bus.beat_cnt !== 5'd1 || bus.addr_valid !== 1'b0) begin
      errs++; $display("FAIL len0_done got d=%b cnt=%0d v=%b exp 1/1/0", bus.done, bus.beat_cnt, bus.addr_valid);
    end
    @(negedge clk);
    kick(4'b0100, 4'hf);
    for (int i = 0; i < 16; i++) begin
      vecs++;
      if (bus.addr !== 4'(4 + i) || bus.done !== 1'b0) begin
        errs++; $display("FAIL max_beat%0d got addr=%b d=%b exp %b/0", i, bus.addr, bus.done, 4'(4 + i));
      end
      @(negedge clk);
    end
    vecs++;
    if (bus.done !== 1'b1 || bus.beat_cnt !== 5'd16 || bus.addr !== 4'b0100) begin
      errs++; $display("FAIL max_done got d=%b cnt=%0d addr=%b exp 1/16/0100", bus.done, bus.beat_cnt, bus.addr);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bus.addr_ready = 1'b0;
    kick(4'b0011, 4'd3);
`ifdef SEQ_STALL_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (bus.addr_valid !== 1'b1 || bus.addr !== 4'b0011) begin
        errs++; $display("FAIL to_stall%0d got v=%b addr=%b exp 1/0011", i, bus.addr_valid, bus.addr);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (bus.addr_valid !== 1'b0 || bus.timeout_err !== 1'b1 || bus.done !== 1'b0 || bus.beat_cnt !== 5'd0) begin
        errs++; $display("FAIL to_abort%0d got v=%b te=%b d=%b cnt=%0d exp 0/1/0/0",
                         i, bus.addr_valid, bus.timeout_err, bus.done, bus.beat_cnt);
      end
      @(negedge clk);
    end
    bus.addr_ready = 1'b1;
    kick(4'b0000, 4'd0);
    vecs++;
    if (bus.timeout_err !== 1'b0 || bus.addr_valid !== 1'b1) begin
      errs++; $display("FAIL to_clear got te=%b v=%b exp 0/1", bus.timeout_err, bus.addr_valid);
    end
    @(negedge clk); @(negedge clk);
`else
    for (int i = 0; i < 55; i++) begin
      vecs++;
      if (bus.addr_valid !== 1'b1 || bus.timeout_err !== 1'b0 || bus.beat_cnt !== 5'd0) begin
        errs++; $display("FAIL stall_hold%0d got v=%b te=%b cnt=%0d exp 1/0/0",
                         i, bus.addr_valid, bus.timeout_err, bus.beat_cnt);
      end
      @(negedge clk);
    end
    bus.addr_ready = 1'b1;
    repeat (4) @(negedge clk);
    vecs++;
    if (bus.done !== 1'b1 || bus.beat_cnt !== 5'd4 || bus.addr !== 4'b0111) begin
      errs++; $display("FAIL stall_done got d=%b cnt=%0d addr=%b exp 1/4/0111", bus.done, bus.beat_cnt, bus.addr);
    end
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_start_ignored();
    test_len_edges();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end
endmodule
